// File: rtl/adc_capture_ctrl.sv
// ADC capture sequencer: arm on start, wait for a trigger edge, skip a delay,
// then gate fixed-length frames of lane samples downstream, N times or forever.
`ifndef NUM_LANES
`define NUM_LANES 4
`endif

module adc_capture_ctrl #(
  parameter int NUM_LANES = `NUM_LANES,
  parameter int LEN_W     = 16,
  parameter int FRM_W     = 8
) (
  input  logic                 adc_clk,
  input  logic                 rst_n,
  input  logic                 cfg_start,
  input  logic                 cfg_abort,
  input  logic [LEN_W-1:0]     cfg_frame_len,
  input  logic [FRM_W-1:0]     cfg_num_frames,
  input  logic [LEN_W-1:0]     cfg_delay,
  input  logic [NUM_LANES-1:0] cfg_lane_mask,
  input  logic                 trig_in,
  input  logic [NUM_LANES-1:0] adc_valid_in,
  input  logic                 ds_ready,
  output logic [NUM_LANES-1:0] cap_en,
  output logic                 sof,
  output logic                 eof,
  output logic                 busy,
  output logic                 done,
  output logic [FRM_W-1:0]     frame_cnt,
  output logic                 ovf_err,
  output logic                 cfg_err
);

  typedef enum logic [2:0] {S_IDLE, S_ARMED, S_DELAY, S_CAPTURE, S_DONE} state_t;

  state_t               r_state;
  logic [LEN_W-1:0]     r_len, r_dly, r_cnt;
  logic [FRM_W-1:0]     r_nfr;
  logic [NUM_LANES-1:0] r_mask;
  logic                 r_trig_prev;

  logic                 w_tick, w_edge, w_cfg_bad, w_len_last, w_dly_last;
  logic [LEN_W-1:0]     w_len_m1, w_dly_m1, w_cnt_inc;
  logic [FRM_W-1:0]     w_fc_next;

  // A tick means every participating lane has a sample this cycle.
  assign w_tick     = &(adc_valid_in | ~r_mask);
  assign w_edge     = trig_in & ~r_trig_prev;
  assign w_cfg_bad  = (cfg_frame_len == '0) || (cfg_lane_mask == '0);
  assign w_len_m1   = r_len - 1'b1;
  assign w_dly_m1   = r_dly - 1'b1;
  assign w_cnt_inc  = r_cnt + 1'b1;
  assign w_len_last = (r_cnt == w_len_m1);
  assign w_dly_last = (r_cnt == w_dly_m1);
  assign w_fc_next  = frame_cnt + 1'b1;

  always_ff @(posedge adc_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_dly       <= '0;
      r_cnt       <= '0;
      r_nfr       <= '0;
      r_mask      <= '0;
      r_trig_prev <= 1'b0;
      cap_en      <= '0;
      sof         <= 1'b0;
      eof         <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      frame_cnt   <= '0;
      ovf_err     <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      r_trig_prev <= trig_in;
      busy        <= (r_state != S_IDLE);
      cap_en      <= '0;
      sof         <= 1'b0;
      eof         <= 1'b0;
      done        <= 1'b0;
      cfg_err     <= 1'b0;
      if (cfg_abort) begin
        r_state <= S_IDLE;
      end else begin
        unique case (r_state)
          S_IDLE: if (cfg_start) begin
            if (w_cfg_bad) begin
              cfg_err <= 1'b1;
            end else begin
              r_len     <= cfg_frame_len;
              r_dly     <= cfg_delay;
              r_nfr     <= cfg_num_frames;
              r_mask    <= cfg_lane_mask;
              r_cnt     <= '0;
              frame_cnt <= '0;
              ovf_err   <= 1'b0;
              r_state   <= S_ARMED;
            end
          end
          S_ARMED: if (w_edge) begin
            r_cnt   <= '0;
            r_state <= (r_dly != '0) ? S_DELAY : S_CAPTURE;
          end
          S_DELAY: if (w_tick) begin
            if (w_dly_last) begin
              r_cnt   <= '0;
              r_state <= S_CAPTURE;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
          S_CAPTURE: if (w_tick) begin
            // The ADC cannot stall, so a refused sample is still counted.
            if (ds_ready) begin
              cap_en <= r_mask;
              sof    <= (r_cnt == '0);
              eof    <= w_len_last;
            end else begin
              ovf_err <= 1'b1;
            end
            if (w_len_last) begin
              r_cnt     <= '0;
              frame_cnt <= w_fc_next;
              r_state   <= ((r_nfr != '0) && (w_fc_next == r_nfr)) ? S_DONE : S_ARMED;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
          S_DONE: begin
            done    <= 1'b1;
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
